apb_reg_slave: RTL and testbench
================================

Name: apb_reg_slave

Overview:
- APB-style register-bank slave downstream of the bridge's APB master.
- Consumes the master's penable/pwrite/pread/paddr/pwdata; returns ready, pslverr and read data.
- Holds NUM_REGS byte-wide read/write registers plus two read-only registers (ID, error count).
- Inserts a programmable number of wait states before every response.

Parameters:
NUM_REGS, 16, number of RW byte registers at addresses 0..NUM_REGS-1 (max 126)
WAIT_STATES, 1, extra cycles inserted before ready (0..15)
ID_VALUE, 8'hA5, constant returned from address 7'h7F

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
apb_penable  input  1  transfer request; held high by master until ready seen
apb_pwrite  input  1  write direction
apb_pread  input  1  read direction
apb_paddr  input  7  register address
apb_pwdata  input  8  write data
apb_ready  output  1  one-cycle response strobe
apb_pslverr  output  1  error flag, valid only while apb_ready=1
apb_prdata  output  8  read data, valid while apb_ready=1 on a good read
busy  output  1  high from transfer capture until return to IDLE

Behaviour:
- Reset (async, rst=1):
  - State=IDLE.
  - apb_ready, apb_pslverr, apb_prdata and busy are 0.
  - All RW registers are 0; error counter is 0.
  - A transfer in flight is dropped and any pending write is not committed.
- Address map:
  - 0..NUM_REGS-1: RW.
  - 7'h7E: error counter, RO, saturates at 8'hFF.
  - 7'h7F: ID_VALUE, RO.
  - Everything else is unmapped.
- States: IDLE, WAIT, RESP, DONE.
- IDLE:
  - On a clock edge with apb_penable=1, capture paddr/pwdata/pwrite/pread and set busy=1.
  - Then go to WAIT and load counter=WAIT_STATES. If WAIT_STATES=0, go directly to RESP.
  - With apb_penable=0, stay in IDLE.
- WAIT: decrement the counter each cycle; move to RESP on the edge where the counter reaches 0.
- Latency: apb_ready is high during the (WAIT_STATES+1)th cycle after the capture edge.
- RESP: registered outputs, apb_ready=1 for exactly one cycle.
  - Error when any of these holds:
    - pwrite and pread both 1, or both 0;
    - address unmapped;
    - write to 7'h7E or 7'h7F.
  - On error:
    - pslverr=1 and prdata=0;
    - no register is modified;
    - the error counter increments, saturating at 8'hFF.
  - Good write: the target register takes the captured pwdata at the clock edge ending RESP; pslverr=0, prdata=0.
  - Good read: prdata = register value at capture time, pslverr=0.
  - Next state is DONE.
- DONE:
  - apb_ready=0 and pslverr=0; prdata holds its last value.
  - Wait for apb_penable=0, then go to IDLE and set busy=0.
- A new transfer is accepted only after apb_penable has been seen low once. This prevents double-response when the master holds penable an extra cycle on its error path.
- Inputs changing during WAIT/RESP are ignored; only captured values are used.
- apb_penable is ignored in WAIT and RESP.
- With NUM_REGS>126, the effective NUM_REGS is 126; 7'h7E/7'h7F always keep their RO roles.

Test Plan:
- Reset value: assert rst mid-WAIT of a write of 8'h3C to addr 2 -> ready never pulses, reg2 reads 8'h00 afterwards, busy=0.
- Good write: WAIT_STATES=1, write 8'h3C to addr 5 -> ready high exactly 2 cycles after the capture edge, pslverr=0. A following read of addr 5 -> prdata=8'h3C, ready 1 cycle wide.
- RO registers: read 7'h7F -> prdata=8'hA5. Write 8'h11 to 7'h7F -> pslverr=1, prdata=0. Read 7'h7E -> 8'h01.
- Unmapped and illegal direction:
  - read addr 7'h40 -> pslverr=1;
  - pwrite=pread=1 to addr 0 -> pslverr=1, reg0 unchanged.
  - Error counter reads 8'h02 afterwards (no prior errors).
- Hold behaviour: after an error response, keep penable high 1 extra cycle -> no second ready; the next transfer is accepted only after penable low.
- Saturation and timing:
  - 300 illegal accesses -> error counter reads 8'hFF.
  - WAIT_STATES=0 -> ready in the cycle directly after capture.

Source files
------------

// File: rtl/apb_reg_slave_if.sv
// apb_reg_slave_if: APB-style request/response bundle between bridge master and register slave
// Ports: penable/pwrite/pread/paddr/pwdata driven by master; ready/pslverr/prdata driven by slave
interface apb_reg_slave_if;
  logic       penable;
  logic       pwrite;
  logic       pread;
  logic [6:0] paddr;
  logic [7:0] pwdata;
  logic       ready;
  logic       pslverr;
  logic [7:0] prdata;
  modport master (output penable, pwrite, pread, paddr, pwdata, input ready, pslverr, prdata);
  modport slave (input penable, pwrite, pread, paddr, pwdata, output ready, pslverr, prdata);
endinterface

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB register bank with RW byte registers, RO ID/error-count and programmable wait states
// Ports: clk, rst (async, active-high); apb (slave side of apb_reg_slave_if); busy (capture until back in IDLE)
module apb_reg_slave #(
  parameter int         NUM_REGS    = 16,
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  apb_reg_slave_if.slave    apb,
  output logic              busy
);
  localparam logic [6:0] NR = 7'(NUM_REGS > 126 ? 126 : NUM_REGS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
  state_t     r_state;
  logic [7:0] r_regs [128];
  logic [7:0] r_errcnt, r_wdata, r_prdata;
  logic [6:0] r_addr;
  logic [3:0] r_cnt;
  logic       r_wr, r_rd, r_ready, r_pslverr, r_busy;
  logic [6:0] w_addr;
  logic [7:0] w_rdata;
  logic       w_wr, w_rd, w_err, w_go;
  assign apb.ready   = r_ready;
  assign apb.pslverr = r_pslverr;
  assign apb.prdata  = r_prdata;
  assign busy        = r_busy;
  // In IDLE the live bus is decoded so a zero-wait transfer can respond on its capture edge.
  always_comb begin
    w_addr  = r_state == IDLE ? apb.paddr : r_addr;
    w_wr    = r_state == IDLE ? apb.pwrite : r_wr;
    w_rd    = r_state == IDLE ? apb.pread : r_rd;
    w_err   = (w_wr == w_rd) || (w_addr >= NR && w_addr < 7'h7E) || (w_wr && w_addr >= 7'h7E);
    w_rdata = (w_err || w_wr) ? 8'h00 : w_addr == 7'h7F ? ID_VALUE : w_addr == 7'h7E ? r_errcnt : r_regs[w_addr];
    w_go    = r_state == IDLE ? apb.penable && WS == 4'd0 : r_state == WAIT && r_cnt == 4'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 8'h00;
      r_busy    <= 1'b0;
      r_errcnt  <= 8'h00;
      r_cnt     <= 4'd0;
      r_addr    <= 7'd0;
      r_wdata   <= 8'h00;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      for (int i = 0; i < 128; i++) r_regs[i] <= 8'h00;
    end else begin
      case (r_state)
        IDLE: if (apb.penable) begin
          r_addr  <= apb.paddr;
          r_wdata <= apb.pwdata;
          r_wr    <= apb.pwrite;
          r_rd    <= apb.pread;
          r_busy  <= 1'b1;
          r_cnt   <= WS;
          r_state <= WAIT;
        end
        WAIT: r_cnt <= r_cnt - 4'd1;
        RESP: begin
          r_ready   <= 1'b0;
          r_pslverr <= 1'b0;
          r_state   <= DONE;
          if (w_err) r_errcnt <= r_errcnt + {7'd0, r_errcnt != 8'hFF};
          else if (r_wr) r_regs[r_addr] <= r_wdata;
        end
        DONE: if (!apb.penable) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      // Response entry overrides the per-state next state chosen above.
      if (w_go) begin
        r_state   <= RESP;
        r_ready   <= 1'b1;
        r_pslverr <= w_err;
        r_prdata  <= w_rdata;
      end
    end
  end
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed scoreboard bench for apb_reg_slave (WAIT_STATES=1 and 0 instances)
module tb_apb_reg_slave;
  localparam int WS = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, busy0;
  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q [$];
  always #5 clk = ~clk;
  apb_reg_slave_if apb ();
  apb_reg_slave_if apb0 ();
  apb_reg_slave #(.NUM_REGS(16), .WAIT_STATES(WS), .ID_VALUE(8'hA5)) dut (
    .clk(clk), .rst(rst), .apb(apb), .busy(busy));
  apb_reg_slave #(.NUM_REGS(16), .WAIT_STATES(0), .ID_VALUE(8'hA5)) dut0 (
    .clk(clk), .rst(rst), .apb(apb0), .busy(busy0));
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Scoreboard: every ready pulse pops one expected {pslverr, prdata}.
  always @(negedge clk) if (apb.ready) begin
    if (exp_q.size() == 0) chk("unexpected_ready", {8'h00, apb.ready}, 9'h000);
    else chk("response", {apb.pslverr, apb.prdata}, exp_q.pop_front());
  end
  task automatic xfer(input logic wr, input logic rd, input logic [6:0] a, input logic [7:0] d,
                      input logic e, input logic [7:0] q, input int hold = 0);
    int n = 0;
    exp_q.push_back({e, q});
    @(negedge clk);
    apb.penable = 1'b1;
    apb.pwrite  = wr;
    apb.pread   = rd;
    apb.paddr   = a;
    apb.pwdata  = d;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        apb.pwrite = ~wr;
        apb.pread  = ~rd;
        apb.paddr  = ~a;
        apb.pwdata = ~d;
      end
    end while (!apb.ready && n < 20);
    chk("latency", 9'(n), 9'(WS + 1));
    if (!apb.ready) void'(exp_q.pop_front());
    chk("busy_in_resp", {8'h00, busy}, 9'h001);
    repeat (hold) begin
      @(negedge clk);
      chk("no_second_ready", {8'h00, apb.ready}, 9'h000);
      chk("busy_in_hold", {8'h00, busy}, 9'h001);
    end
    apb.penable = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", {8'h00, apb.ready}, 9'h000);
    @(negedge clk);
    chk("busy_idle", {8'h00, busy}, 9'h000);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  initial begin
    {apb.penable, apb.pwrite, apb.pread, apb.paddr, apb.pwdata} = '0;
    {apb0.penable, apb0.pwrite, apb0.pread, apb0.paddr, apb0.pwdata} = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {8'h00, apb.ready}, 9'h000);
    chk("rst_pslverr", {8'h00, apb.pslverr}, 9'h000);
    chk("rst_prdata", {1'b0, apb.prdata}, 9'h000);
    chk("rst_busy", {8'h00, busy}, 9'h000);
    rst = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    apb.pwrite  = 1'b1;
    apb.pread   = 1'b0;
    apb.paddr   = 7'd2;
    apb.pwdata  = 8'h3C;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rstwait_ready", {8'h00, apb.ready}, 9'h000);
    chk("rstwait_busy", {8'h00, busy}, 9'h000);
    apb.penable = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstwait_no_ready", {8'h00, apb.ready}, 9'h000);
    end
    xfer(1'b0, 1'b1, 7'd2, 8'h00, 1'b0, 8'h00);
    xfer(1'b1, 1'b0, 7'd5, 8'h3C, 1'b0, 8'h00);
    xfer(1'b0, 1'b1, 7'd5, 8'h00, 1'b0, 8'h3C);
    xfer(1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 8'hA5);
    xfer(1'b1, 1'b0, 7'h7F, 8'h11, 1'b1, 8'h00);
    xfer(1'b0, 1'b1, 7'h7E, 8'h00, 1'b0, 8'h01);
    do_reset();
    xfer(1'b0, 1'b1, 7'h40, 8'h00, 1'b1, 8'h00);
    xfer(1'b1, 1'b1, 7'd0, 8'hFF, 1'b1, 8'h00);
    xfer(1'b0, 1'b1, 7'd0, 8'h00, 1'b0, 8'h00);
    xfer(1'b0, 1'b1, 7'h7E, 8'h00, 1'b0, 8'h02);
    xfer(1'b1, 1'b0, 7'd15, 8'h9A, 1'b0, 8'h00);
    xfer(1'b0, 1'b1, 7'd15, 8'h00, 1'b0, 8'h9A);
    xfer(1'b0, 1'b1, 7'd16, 8'h00, 1'b1, 8'h00);
    xfer(1'b1, 1'b0, 7'h7E, 8'h44, 1'b1, 8'h00);
    xfer(1'b0, 1'b1, 7'h7E, 8'h00, 1'b0, 8'h04);
    xfer(1'b0, 1'b1, 7'h50, 8'h00, 1'b1, 8'h00, 3);
    xfer(1'b1, 1'b0, 7'd5, 8'h6B, 1'b0, 8'h00, 2);
    xfer(1'b0, 1'b1, 7'd5, 8'h00, 1'b0, 8'h6B);
    xfer(1'b0, 1'b0, 7'd1, 8'h12, 1'b1, 8'h00);
    xfer(1'b0, 1'b1, 7'h7E, 8'h00, 1'b0, 8'h06);
    for (int i = 0; i < 300; i++) xfer(1'b1, 1'b1, 7'd0, 8'h55, 1'b1, 8'h00);
    xfer(1'b0, 1'b1, 7'h7E, 8'h00, 1'b0, 8'hFF);
    xfer(1'b0, 1'b1, 7'd0, 8'h00, 1'b0, 8'h00);
    chk("queue_drained", 9'(exp_q.size()), 9'd0);
    @(negedge clk);
    apb0.penable = 1'b1;
    apb0.pwrite  = 1'b1;
    apb0.pread   = 1'b0;
    apb0.paddr   = 7'd3;
    apb0.pwdata  = 8'h77;
    @(negedge clk);
    chk("ws0_wr_ready", {8'h00, apb0.ready}, 9'h001);
    chk("ws0_wr_resp", {apb0.pslverr, apb0.prdata}, 9'h000);
    apb0.penable = 1'b0;
    @(negedge clk);
    chk("ws0_wr_one_cycle", {8'h00, apb0.ready}, 9'h000);
    @(negedge clk);
    chk("ws0_busy_idle", {8'h00, busy0}, 9'h000);
    apb0.penable = 1'b1;
    apb0.pwrite  = 1'b0;
    apb0.pread   = 1'b1;
    @(negedge clk);
    chk("ws0_rd_ready", {8'h00, apb0.ready}, 9'h001);
    chk("ws0_rd_resp", {apb0.pslverr, apb0.prdata}, {1'b0, 8'h77});
    apb0.penable = 1'b0;
    @(negedge clk);
    chk("ws0_rd_one_cycle", {8'h00, apb0.ready}, 9'h000);
    @(negedge clk);
    apb0.penable = 1'b1;
    apb0.pwrite  = 1'b1;
    apb0.pread   = 1'b0;
    apb0.paddr   = 7'h7E;
    @(negedge clk);
    chk("ws0_ro_ready", {8'h00, apb0.ready}, 9'h001);
    chk("ws0_ro_resp", {apb0.pslverr, apb0.prdata}, {1'b1, 8'h00});
    apb0.penable = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
